// File: rtl/edge_detect_multi.sv
// edge_detect_multi: N-channel synchronised edge detector.
// Each channel synchronises an asynchronous level, tracks it with a two-state
// FSM, and emits a one-cycle Mealy tick on the rising edge, the falling edge,
// or both, as chosen by that channel's mode bits. Every tick sets a sticky
// pending flag and bumps a saturating event counter. Both are cleared by
// writing 1 to clr. A shared warm-up counter keeps ticks suppressed until the
// synchronisers hold real samples, so a level that is already high when reset
// is released is not reported as an edge.
module edge_detect_multi #(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       level,
   input  logic [2*N-1:0]     mode,
   input  logic [N-1:0]       clr,
   output logic [N-1:0]       tick,
   output logic [N-1:0]       pending,
   output logic [N*CNT_W-1:0] cnt,
   output logic               irq
);

   typedef enum logic {
      ZERO = 1'b0,
      ONE  = 1'b1
   } state_t;

   // Warm-up completes after SYNC_STAGES+1 clocks: by then every synchroniser
   // stage holds a real sample and each FSM has loaded it once.
   localparam int WARM_MAX = SYNC_STAGES + 1;
   localparam int WARM_W   = $clog2(WARM_MAX + 1);
   localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(WARM_MAX);

   logic [WARM_W-1:0] warm;
   logic              enable;

   // Shared warm-up counter; restarts on every reset and then saturates.
   // NOTE: sequential state always uses non-blocking (<=) so every flop
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         warm <= '0;
      end else if (warm != WARM_DONE) begin
         warm <= warm + 1'b1;
      end
   end

   assign enable = (warm == WARM_DONE);

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] chain;
      logic                   sync;
      state_t                 state_q;
      state_t                 state_d;
      logic                   rise;
      logic                   fall;
      logic                   hit;
      logic                   pend_q;
      logic [CNT_W-1:0]       count_q;

      // Synchroniser chain; chain[0] samples the asynchronous input.
      always_ff @(posedge clk) begin
         if (reset) begin
            chain <= '0;
         end else begin
            chain <= {chain[SYNC_STAGES-2:0], level[i]};
         end
      end

      assign sync = chain[SYNC_STAGES-1];

      // Edge-tracking FSM state register; it follows sync whatever the mode.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= ZERO;
         end else begin
            state_q <= state_d;
         end
      end

      // Next state plus the rise/fall qualifiers, decoded from state and sync.
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      always_comb begin
         state_d = ZERO;
         rise    = 1'b0;
         fall    = 1'b0;
         case (state_q)
            ZERO: begin
               if (sync) begin
                  state_d = ONE;
                  rise    = 1'b1;
               end else begin
                  state_d = ZERO;
               end
            end
            ONE: begin
               if (!sync) begin
                  state_d = ZERO;
                  fall    = 1'b1;
               end else begin
                  state_d = ONE;
               end
            end
            default: state_d = ZERO;
         endcase
      end

      // Rise and fall are mutually exclusive, so mode 11 never ticks twice
      // for one transition.
      assign hit     = enable & ((rise & mode[2*i]) | (fall & mode[2*i+1]));
      assign tick[i] = hit;

      // Sticky pending flag; a new event wins over a same-cycle clear.
      always_ff @(posedge clk) begin
         if (reset) begin
            pend_q <= 1'b0;
         end else if (hit) begin
            pend_q <= 1'b1;
         end else if (clr[i]) begin
            pend_q <= 1'b0;
         end
      end

      assign pending[i] = pend_q;

      // Saturating event counter; a clear coinciding with an event leaves 1.
      always_ff @(posedge clk) begin
         if (reset) begin
            count_q <= '0;
         end else if (clr[i] && hit) begin
            count_q <= CNT_W'(1);
         end else if (clr[i]) begin
            count_q <= '0;
         end else if (hit && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
         end
      end

      assign cnt[i*CNT_W +: CNT_W] = count_q;
   end

   assign irq = |pending;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi (N=4, SYNC_STAGES=2, CNT_W=3).
// A history-based reference model runs alongside every cycle. Directed
// sequences also check hand-derived constants.
module tb_edge_detect_multi;

   localparam int N    = 4;
   localparam int S    = 2;
   localparam int CW   = 3;
   localparam int MAXC = (1 << CW) - 1;

   logic            clk   = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    level = '0;
   logic [2*N-1:0]  mode  = '0;
   logic [N-1:0]    clr   = '0;
   logic [N-1:0]    tick;
   logic [N-1:0]    pending;
   logic [N*CW-1:0] cnt;
   logic            irq;

   always #5 clk = ~clk;

   edge_detect_multi #(.N(N), .SYNC_STAGES(S), .CNT_W(CW)) dut (
      .clk     (clk),
      .reset   (reset),
      .level   (level),
      .mode    (mode),
      .clr     (clr),
      .tick    (tick),
      .pending (pending),
      .cnt     (cnt),
      .irq     (irq)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[m-1] is the level seen at the m-th clock edge since reset release.
   // The synchronised value after edge e is the level from edge e-S+1; an edge
   // is a change of that value from one cycle to the next.
   logic [N-1:0] hist[$];
   int           e_m    = 0;
   logic [N-1:0] pend_m = '0;
   int           cnt_m[N];

   initial for (int c = 0; c < N; c++) cnt_m[c] = 0;

   function automatic logic model_tick_bit(input int ch);
      logic now_v;
      logic prev_v;
      if (e_m < S + 1) return 1'b0;
      now_v  = hist[e_m-S][ch];
      prev_v = hist[e_m-S-1][ch];
      return (now_v & ~prev_v & mode[2*ch]) | (~now_v & prev_v & mode[2*ch+1]);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         hist.delete();
         e_m    <= 0;
         pend_m <= '0;
         for (int c = 0; c < N; c++) cnt_m[c] <= 0;
      end else begin
         for (int c = 0; c < N; c++) begin
            if (model_tick_bit(c)) pend_m[c] <= 1'b1;
            else if (clr[c])       pend_m[c] <= 1'b0;
            if (clr[c] && model_tick_bit(c))                 cnt_m[c] <= 1;
            else if (clr[c])                                 cnt_m[c] <= 0;
            else if (model_tick_bit(c) && cnt_m[c] < MAXC)   cnt_m[c] <= cnt_m[c] + 1;
         end
         hist.push_back(level);
         e_m <= e_m + 1;
      end
   end

   task automatic check_model();
      logic [N-1:0] exp_tick;
      exp_tick = '0;
      for (int c = 0; c < N; c++) exp_tick[c] = model_tick_bit(c);
      check("model tick", tick, exp_tick);
      check("model pending", pending, pend_m);
      check("model irq", irq, |pend_m);
      for (int c = 0; c < N; c++) check($sformatf("model cnt[%0d]", c), cnt[c*CW +: CW], cnt_m[c]);
   endtask

   // Drive one cycle of inputs just after the falling edge, then compare.
   task automatic step(input logic rs, input logic [N-1:0] lv,
                       input logic [2*N-1:0] md, input logic [N-1:0] cl);
      @(negedge clk);
      reset = rs;
      level = lv;
      mode  = md;
      clr   = cl;
      #1;
      check_model();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [N-1:0]   lv;
      logic [2*N-1:0] md;
      logic [N-1:0]   cl;
      logic [N-1:0]   tk;
      logic [N-1:0]   pd;
      logic [CW-1:0]  c0;
   } vec_t;

   vec_t tbl[20];

   initial begin
      logic [9:0]     mask;
      logic [2*N-1:0] md;
      logic [N-1:0]   lv;
      logic           acc;
      int             nt;

      // Rows 0-5: level[0] high from reset release, mode 11 -> never a tick.
      for (int j = 0; j < 6; j++) tbl[j] = '{4'b0001, 8'b00_00_00_11, 4'b0000, 4'b0000, 4'b0000, 3'd0};
      // Rows 6-9: fall with rising-only mode -> no tick.
      for (int j = 6; j < 10; j++) tbl[j] = '{4'b0000, 8'b00_00_00_01, 4'b0000, 4'b0000, 4'b0000, 3'd0};
      // Rows 10-13: rise applied before edge 11 -> tick in row 12, count in row 13.
      tbl[10] = '{4'b0001, 8'b00_00_00_01, 4'b0000, 4'b0000, 4'b0000, 3'd0};
      tbl[11] = '{4'b0001, 8'b00_00_00_01, 4'b0000, 4'b0000, 4'b0000, 3'd0};
      tbl[12] = '{4'b0001, 8'b00_00_00_01, 4'b0000, 4'b0001, 4'b0000, 3'd0};
      tbl[13] = '{4'b0001, 8'b00_00_00_01, 4'b0000, 4'b0000, 4'b0001, 3'd1};
      // Rows 14-17: later fall gives no tick.
      for (int j = 14; j < 18; j++) tbl[j] = '{4'b0000, 8'b00_00_00_01, 4'b0000, 4'b0000, 4'b0001, 3'd1};
      // Row 18 clears at its edge; row 19 shows the result.
      tbl[18] = '{4'b0000, 8'b00_00_00_01, 4'b0001, 4'b0000, 4'b0001, 3'd1};
      tbl[19] = '{4'b0000, 8'b00_00_00_01, 4'b0000, 4'b0000, 4'b0000, 3'd0};

      // Reset state.
      step(1'b1, '0, '0, '0);
      check("reset tick", tick, 0);
      check("reset pending", pending, 0);
      check("reset cnt", cnt, 0);
      check("reset irq", irq, 0);
      step(1'b1, '0, '0, '0);

      for (int j = 0; j < 20; j++) begin
         step(1'b0, tbl[j].lv, tbl[j].md, tbl[j].cl);
         check($sformatf("row%0d tick", j), tick, tbl[j].tk);
         check($sformatf("row%0d pending", j), pending, tbl[j].pd);
         check($sformatf("row%0d cnt0", j), cnt[0 +: CW], tbl[j].c0);
         check($sformatf("row%0d irq", j), irq, |tbl[j].pd);
      end

      // ch1: 3-cycle pulse with mode 11 -> ticks 3 cycles apart.
      mask = '0;
      for (int j = 0; j < 10; j++) begin
         step(1'b0, (j < 3) ? 4'b0010 : 4'b0000, 8'b00_00_11_00, '0);
         mask[j] = tick[1];
      end
      check("pulse m11 ticks", mask, 10'b00_0010_0100);
      check("pulse m11 cnt1", cnt[CW +: CW], 2);
      check("pulse m11 pending1", pending[1], 1);

      // Same pulse with mode 10 -> only the fall ticks.
      mask = '0;
      for (int j = 0; j < 10; j++) begin
         step(1'b0, (j < 3) ? 4'b0010 : 4'b0000, 8'b00_00_10_00, '0);
         mask[j] = tick[1];
      end
      check("pulse m10 ticks", mask, 10'b00_0010_0000);
      check("pulse m10 cnt1", cnt[CW +: CW], 3);

      // ch2: ten transitions with mode 11 -> counter saturates at 7.
      md = 8'b00_11_00_00;
      nt = 0;
      for (int j = 0; j < 24; j++) begin
         lv = (j < 20 && ((j + 2) / 2) % 2 == 1) ? 4'b0100 : 4'b0000;
         step(1'b0, lv, md, '0);
         if (tick[2]) nt++;
      end
      check("toggle tick count", nt, 10);
      check("saturated cnt2", cnt[2*CW +: CW], MAXC);
      check("saturated pending2", pending[2], 1);

      // Clear coinciding with a tick: event wins pending, count restarts at 1.
      step(1'b0, 4'b0100, md, '0);
      step(1'b0, 4'b0100, md, '0);
      step(1'b0, 4'b0100, md, 4'b0100);
      check("clr+tick tick2", tick[2], 1);
      step(1'b0, 4'b0100, md, '0);
      check("clr+tick pending2", pending[2], 1);
      check("clr+tick cnt2", cnt[2*CW +: CW], 1);

      // ch3: mode switched 00 -> 11 while level is stable high -> no tick.
      acc = 1'b0;
      for (int j = 0; j < 5; j++) begin
         step(1'b0, 4'b1100, 8'b00_11_00_00, '0);
         acc |= tick[3];
      end
      for (int j = 0; j < 6; j++) begin
         step(1'b0, 4'b1100, 8'b11_11_00_00, '0);
         acc |= tick[3];
      end
      check("mode switch no tick", acc, 0);

      // Mid-run reset with pending/cnt nonzero.
      step(1'b1, 4'b1100, 8'b11_11_00_00, '0);
      check("pre-reset pending", pending, 4'b0110);
      step(1'b0, 4'b1100, 8'b11_11_00_00, '0);
      check("post-reset pending", pending, 0);
      check("post-reset cnt", cnt, 0);
      check("post-reset irq", irq, 0);
      acc = 1'b0;
      for (int j = 0; j < 6; j++) begin
         step(1'b0, 4'b1100, 8'b11_11_00_00, '0);
         acc |= |tick;
      end
      check("rewarm no tick", acc, 0);

      // All channels toggle on the same edge with mode 11.
      for (int j = 0; j < 3; j++) step(1'b0, 4'b1100, 8'hFF, '0);
      step(1'b0, 4'b0011, 8'hFF, '0);
      step(1'b0, 4'b0011, 8'hFF, '0);
      step(1'b0, 4'b0011, 8'hFF, '0);
      check("all tick", tick, 4'b1111);
      step(1'b0, 4'b0011, 8'hFF, '0);
      check("all pending", pending, 4'b1111);
      for (int c = 0; c < N; c++) check($sformatf("all cnt[%0d]", c), cnt[c*CW +: CW], 1);

      // Randomised traffic against the model.
      lv = 4'b0011;
      md = 8'hFF;
      for (int j = 0; j < 800; j++) begin
         logic [N-1:0] cl;
         logic         rs;
         for (int c = 0; c < N; c++) if ($urandom_range(3) == 0) lv[c] = ~lv[c];
         if ($urandom_range(15) == 0) md = 8'($urandom);
         cl = '0;
         for (int c = 0; c < N; c++) cl[c] = ($urandom_range(7) == 0);
         rs = ($urandom_range(199) == 0);
         step(rs, lv, md, cl);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/edge_detect_multi.md
# edge_detect_multi

Parametrised multi-channel edge detector, the successor of the single-channel dual-edge Mealy detector. Each channel synchronises an asynchronous level input and emits a one-cycle Mealy tick on rising, falling, or both edges, selected per channel at run time. Each channel also keeps a sticky pending flag and a saturating event counter. Sits between raw external inputs (buttons, sensor strobes) and the control FSMs or the status/interrupt logic.

## Interface

- N, 4, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
- CNT_W, 8, width of each per-channel event counter
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- level  in  N  asynchronous level inputs, bit i = channel i
- mode  in  2N  per-channel select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clr  in  N  write-1-to-clear for pending[i] and cnt[i]
- tick  out  N  one-cycle pulse per qualifying edge (Mealy, combinational from state + synced level + mode)
- pending  out  N  sticky: set by tick[i], cleared by clr[i]
- cnt  out  N*CNT_W  per-channel saturating event count, channel i at [i*CNT_W +: CNT_W]
- irq  out  1  OR of pending

## Operation

- Per channel, the synchroniser chain feeds the level into sync[i], which is the last stage.
- Per channel, a 2-state FSM (ZERO, ONE) tracks sync[i]:
  - ZERO -> ONE when sync[i]=1; this is a rise.
  - ONE -> ZERO when sync[i]=0; this is a fall.
  - Otherwise the FSM holds.
- The FSM tracks sync[i] every cycle regardless of mode. Changing mode therefore never fabricates an edge.
- tick[i] = enable & ((rise & mode[2i]) | (fall & mode[2i+1])).
- Mode 00: tick, pending and cnt do not change for that channel. The FSM still tracks.
- Warm-up:
  - A shared counter warm counts rising edges with reset low and saturates at SYNC_STAGES+1.
  - enable = (warm == SYNC_STAGES+1).
  - While enable=0, tick=0 and the FSM still loads sync[i]. A level already high at reset release therefore produces no tick.
- pending[i] on a clock edge:
  - If tick[i]=1, pending <= 1, including when clr[i]=1 in the same cycle (event wins).
  - Else if clr[i]=1, pending <= 0.
  - Otherwise pending holds.
- cnt[i] on a clock edge:
  - If clr[i] & tick[i], cnt <= 1.
  - Else if clr[i], cnt <= 0.
  - Else if tick[i] and cnt not all-ones, cnt <= cnt+1.
  - Saturates at 2^CNT_W-1 and does not wrap.
- A single level transition produces at most one tick, even with mode 11.
- Channels are fully independent; simultaneous events on multiple channels are all counted.
- Default FSM branch returns to ZERO.

## Timing

- Reset values: sync chains 0, FSM ZERO, warm 0, tick 0, pending 0, cnt 0, irq 0.
- Reset asserted mid-operation takes effect at the next rising clock edge:
  - All state above returns to its reset value.
  - Warm-up restarts.
  - Ticks in flight are dropped.
- Latency: a level held stable from before edge k reaches sync[i] after edge k+SYNC_STAGES-1. tick is high for exactly the one cycle between edges k+SYNC_STAGES-1 and k+SYNC_STAGES.
- pending, cnt and FSM state update at edge k+SYNC_STAGES. irq follows pending combinationally, with no additional latency.
- Pulses shorter than one clock may be missed. A pulse of >=2 cycles, with mode 11 and after warm-up, yields two ticks separated by the pulse width.
- clr acts on the edge where it is high; no hold requirement.

## Test plan

- Reset, then hold level[0]=1 from reset release, mode=11, SYNC_STAGES=2 -> no tick during the first 3 enabled-check cycles or afterwards; pending=0, cnt=0.
- After warm-up, ch0 mode=01, drive level 0->1 before edge k -> tick[0] high only in the cycle after edge k+1; pending[0]=1 and cnt[0]=1 after edge k+2; irq=1. A later 1->0 transition gives no tick.
- ch1 mode=11, 3-cycle high pulse -> two ticks 3 cycles apart; cnt[1]=2. Same pulse with mode=10 -> one tick, on the fall.
- CNT_W=3, ch2 mode=11, 10 toggles -> cnt[2] reaches 7 and stays at 7. Then clr[2] coinciding with a tick -> pending[2]=1, cnt[2]=1.
- Switch ch3 mode 00->11 while level[3] is stable high -> no tick. Assert reset mid-run with pending/cnt nonzero -> all cleared at that edge and warm-up repeats.
- All N channels toggled on the same edge with mode=11 -> all tick bits high in the same cycle; every cnt increments by 1.
